// File: rtl/mu0_reg_bank.sv
// MU0 register bank: DEPTH x WIDTH registers, one write port, one increment port,
// two combinational read ports and a one-deep shadow copy for context save/restore.
module mu0_reg_bank #(
  parameter int                 WIDTH       = 16,
  parameter int                 DEPTH       = 4,
  parameter int                 AW          = 4,
  parameter int                 BYPASS      = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WEn,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] WData,
  input  logic             IncEn,
  input  logic [AW-1:0]    IncAddr,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] RDataA,
  output logic [WIDTH-1:0] RDataB,
  input  logic             Save,
  input  logic             Restore,
  output logic             ShadowValid
);

  logic [WIDTH-1:0] reg_q    [DEPTH];
  logic [WIDTH-1:0] reg_d    [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic             valid_q;
  logic             valid_d;
  logic             waddr_ok;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    reg_d    = reg_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    waddr_ok = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (WAddr == AW'(i)) waddr_ok = 1'b1;
    end

    if (Restore) begin
      reg_d = shadow_q;
    end else begin
      // Increment first so a write to the same register overrides it.
      for (int i = 0; i < DEPTH; i++) begin
        if (IncEn && IncAddr == AW'(i)) reg_d[i] = reg_q[i] + WIDTH'(1);
        if (WEn && WAddr == AW'(i))     reg_d[i] = WData;
      end
    end

    // Save reads pre-edge live values, so Save+Restore is a clean swap.
    if (Save) begin
      shadow_d = reg_q;
      valid_d  = 1'b1;
    end else if (Restore) begin
      valid_d  = 1'b0;
    end
  end

  // NOTE: the whole bank is reset because a restore right after reset must load RESET_VALUE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]    <= RESET_VALUE;
        shadow_q[i] <= RESET_VALUE;
      end
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment; comb logic above uses blocking.
      reg_q    <= reg_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    RDataA = '0;
    RDataB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RAddrA == AW'(i)) RDataA = reg_q[i];
      if (RAddrB == AW'(i)) RDataB = reg_q[i];
    end
    // Forwarding is suppressed in reset so reads show RESET_VALUE while it is held.
    if (BYPASS != 0 && Reset && WEn && !Restore && waddr_ok) begin
      if (RAddrA == WAddr) RDataA = WData;
      if (RAddrB == WAddr) RDataB = WData;
    end
  end

  assign ShadowValid = valid_q;

endmodule
